decimal_key_entry: RTL and testbench

DECIMAL_KEY_ENTRY -- requirements
Module: decimal_key_entry

---
 rtl/decimal_key_entry_pkg.sv | 13 +
 rtl/decimal_key_entry_if.sv | 15 +
 rtl/decimal_key_entry_debounce.sv | 37 +++
 rtl/decimal_key_entry.sv | 63 ++++++
 tb/tb_decimal_key_entry.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/decimal_key_entry_pkg.sv
// decimal_key_entry_pkg: shared entry-FSM states, digit count and debounce default.
package decimal_key_entry_pkg;

    localparam int DIGITS      = 10;
    localparam int DEB_DEFAULT = 16;

    typedef enum logic [1:0] {WAIT_A, WAIT_B, DONE} state_t;

    function automatic logic is_onehot(input logic [DIGITS-1:0] v);
        return v != '0 && (v & (v - 1'b1)) == '0;
    endfunction

endpackage

// File: rtl/decimal_key_entry_if.sv
// decimal_key_entry_if: keypad inputs and one-hot operand outputs of the key entry block.
interface decimal_key_entry_if;
    import decimal_key_entry_pkg::*;

    logic [DIGITS-1:0] key_in;
    logic              clear;
    logic [DIGITS-1:0] A;
    logic [DIGITS-1:0] B;
    logic              valid;
    logic              err;

    modport master (output key_in, clear, input A, B, valid, err);
    modport slave  (input key_in, clear, output A, B, valid, err);

endinterface

// File: rtl/decimal_key_entry_debounce.sv
// key_debounce: two-flop synchronizer plus stability counter; key_db follows the
// synchronized vector once it has held unchanged for DEB_CYCLES cycles.
module key_debounce #(
    parameter int WIDTH      = 10,
    parameter int DEB_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] key_db
);
    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic [WIDTH-1:0] s1, s2, s3;
    logic [CW-1:0]    cnt;

    // s3 is the previous synchronized value, so a change restarts the run at one cycle held
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            s1     <= '0;
            s2     <= '0;
            s3     <= '0;
            cnt    <= '0;
            key_db <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            s3 <= s2;
            if (s2 != s3)
                cnt <= CW'(1);
            else if (cnt == CW'(DEB_CYCLES - 1))
                key_db <= s2;
            else
                cnt <= cnt + 1'b1;
        end

endmodule

// File: rtl/decimal_key_entry.sv
// decimal_key_entry: debounced decimal keypad capturing two one-hot operand digits A and B.
module decimal_key_entry
    import decimal_key_entry_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_DEFAULT
) (
    input logic                 clk,
    input logic                 rst,
    decimal_key_entry_if.slave  bus
);
    logic [DIGITS-1:0] key_db, prev_db, a_n, b_n;
    logic              press, multi;
    state_t            state, state_n;

    key_debounce #(.WIDTH(DIGITS), .DEB_CYCLES(DEB_CYCLES)) u_deb (
        .clk    (clk),
        .rst    (rst),
        .raw    (bus.key_in),
        .key_db (key_db)
    );

    // only a transition out of all-released counts, so held or rolled keys never re-trigger
    assign press = prev_db == '0 && is_onehot(key_db);
    assign multi = prev_db == '0 && key_db != '0 && !is_onehot(key_db);

    always_comb begin
        state_n = state;
        a_n     = bus.A;
        b_n     = bus.B;
        if (bus.clear) begin
            state_n = WAIT_A;
            a_n     = '0;
            b_n     = '0;
        end else if (press) begin
            if (state == WAIT_B) begin
                b_n     = key_db;
                state_n = DONE;
            end else begin
                a_n     = key_db;
                b_n     = '0;
                state_n = WAIT_B;
            end
        end
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state     <= WAIT_A;
            prev_db   <= '0;
            bus.A     <= '0;
            bus.B     <= '0;
            bus.valid <= 1'b0;
            bus.err   <= 1'b0;
        end else begin
            state     <= state_n;
            prev_db   <= key_db;
            bus.A     <= a_n;
            bus.B     <= b_n;
            bus.valid <= state_n == DONE;
            bus.err   <= multi;
        end

endmodule

// File: tb/tb_decimal_key_entry.sv
// tb_decimal_key_entry: directed keypad scenarios checked every cycle against a
// sample-history model of the entry block, plus literal expectations per scenario.
module tb_decimal_key_entry;
    localparam int DEB = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    decimal_key_entry_if bus();

    decimal_key_entry #(.DEB_CYCLES(DEB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic lit(input string nm, input logic [9:0] got, input logic [9:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic entry(input logic [9:0] v);
        bus.key_in = v;
        cyc(10);
        bus.key_in = '0;
        cyc(10);
    endtask

    // model: accepted vector = raw value that filled the last DEB samples ending two edges ago
    logic [9:0] m_a, m_b, kd, pk;
    logic       m_valid, m_err;
    int         phase;
    logic [9:0] hist[$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_a = '0; m_b = '0; m_valid = 0; m_err = 0; kd = '0; pk = '0; phase = 0;
            hist = {};
            repeat (DEB + 2) hist.push_back('0);
        end else begin
            logic pr, same;
            pr    = pk == '0 && $onehot(kd);
            m_err = pk == '0 && kd != '0 && !$onehot(kd);
            if (bus.clear) begin
                m_a = '0; m_b = '0; phase = 0;
            end else if (pr) begin
                if (phase == 1) begin
                    m_b = kd; phase = 2;
                end else begin
                    m_a = kd; m_b = '0; phase = 1;
                end
            end
            m_valid = phase == 2;
            pk = kd;
            hist.push_back(bus.key_in);
            void'(hist.pop_front());
            same = 1'b1;
            for (int i = 1; i < DEB; i++) if (hist[i] != hist[0]) same = 1'b0;
            if (same) kd = hist[0];
        end
    end

    always @(negedge clk) begin
        #2;
        lit("model_A", bus.A, m_a);
        lit("model_B", bus.B, m_b);
        lit("model_valid", {9'b0, bus.valid}, {9'b0, m_valid});
        lit("model_err", {9'b0, bus.err}, {9'b0, m_err});
    end

    initial begin
        bus.key_in = '0;
        bus.clear  = 1'b0;
        cyc(3);
        #3 lit("rst_A", bus.A, 10'h000);
        lit("rst_B", bus.B, 10'h000);
        lit("rst_valid", {9'b0, bus.valid}, 10'h000);
        lit("rst_err", {9'b0, bus.err}, 10'h000);
        cyc(1); rst = 1'b0;
        cyc(2);
        // digit 3 then digit 5
        bus.key_in = 10'h008; cyc(6);
        #3 lit("a3_early", bus.A, 10'h000);
        cyc(1);
        #3 lit("a3_A", bus.A, 10'h008);
        lit("a3_valid", {9'b0, bus.valid}, 10'h000);
        cyc(3); bus.key_in = '0; cyc(10);
        bus.key_in = 10'h020; cyc(6);
        #3 lit("b5_early", bus.B, 10'h000);
        cyc(1);
        #3 lit("b5_B", bus.B, 10'h020);
        lit("b5_A", bus.A, 10'h008);
        lit("b5_valid", {9'b0, bus.valid}, 10'h001);
        cyc(3); bus.key_in = '0; cyc(10);
        // 2-cycle glitch on digit 9 in WAIT_A
        bus.clear = 1'b1; cyc(1); bus.clear = 1'b0; cyc(2);
        bus.key_in = 10'h200; cyc(2); bus.key_in = '0; cyc(10);
        #3 lit("glitch_A", bus.A, 10'h000);
        lit("glitch_err", {9'b0, bus.err}, 10'h000);
        // digits 1 and 2 together, then digit 2
        cyc(1); bus.key_in = 10'h006; cyc(7);
        #3 lit("multi_err", {9'b0, bus.err}, 10'h001);
        lit("multi_A", bus.A, 10'h000);
        cyc(1);
        #3 lit("multi_err_end", {9'b0, bus.err}, 10'h000);
        cyc(2); bus.key_in = '0; cyc(10);
        bus.key_in = 10'h004; cyc(7);
        #3 lit("d2_A", bus.A, 10'h004);
        cyc(3); bus.key_in = '0; cyc(10);
        // DONE with 4,6 then digit 0
        bus.clear = 1'b1; cyc(1); bus.clear = 1'b0;
        entry(10'h010); entry(10'h040);
        #3 lit("done_A", bus.A, 10'h010);
        lit("done_B", bus.B, 10'h040);
        lit("done_valid", {9'b0, bus.valid}, 10'h001);
        cyc(1); bus.key_in = 10'h001; cyc(7);
        #3 lit("d0_A", bus.A, 10'h001);
        lit("d0_B", bus.B, 10'h000);
        lit("d0_valid", {9'b0, bus.valid}, 10'h000);
        cyc(3); bus.key_in = '0; cyc(10);
        // clear on press cycle in WAIT_B
        bus.key_in = 10'h080; cyc(6);
        bus.clear = 1'b1; cyc(1); bus.clear = 1'b0;
        #3 lit("clr_A", bus.A, 10'h000);
        lit("clr_B", bus.B, 10'h000);
        cyc(9);
        #3 lit("clr_lost_A", bus.A, 10'h000);
        lit("clr_lost_valid", {9'b0, bus.valid}, 10'h000);
        cyc(1); bus.key_in = '0; cyc(10);
        // same digit for both operands
        entry(10'h080); entry(10'h080);
        #3 lit("77_A", bus.A, 10'h080);
        lit("77_B", bus.B, 10'h080);
        lit("77_valid", {9'b0, bus.valid}, 10'h001);
        // rst mid-debounce of held digit 8
        cyc(1); bus.key_in = 10'h100; cyc(2);
        rst = 1'b1;
        #3 lit("rst_mid_A", bus.A, 10'h000);
        lit("rst_mid_valid", {9'b0, bus.valid}, 10'h000);
        cyc(1); rst = 1'b0; cyc(6);
        #3 lit("d8_early", bus.A, 10'h000);
        cyc(1);
        #3 lit("d8_A", bus.A, 10'h100);
        cyc(3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
